// File: rtl/riscv_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_wb_pkg
//  Purpose  : Shared types and constants for the writeback arbiter slice.
//             Holds the default data/register-index widths, the queue entry
//             type {rd, data} and the x0 register index.
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    // One pending register-file write.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // Writes to x0 are architecturally discarded.
    localparam logic [WB_ADDR_W-1:0] X0 = '0;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_fifo
//  Purpose  : In-order FIFO of wb_entry_t with two push ports and one pop
//             port per cycle. Push port 0 is ordered ahead of push port 1.
//             Exposes the occupancy and each slot's valid/rd so the parent
//             can build a pending-destination mask.
//  Ports    : clk, rst_n           - clock, async active-low reset
//             push0_en/push0_entry - first push of the cycle
//             push1_en/push1_entry - second push of the cycle
//             pop_en               - remove head (only when count > 0)
//             head                 - entry at the read pointer
//             count                - occupied entries, 0..DEPTH
//             entry_valid/entry_rd - per-slot occupancy and destination
//  Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import riscv_wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push0_en,
    input  wb_entry_t                       push0_entry,
    input  logic                            push1_en,
    input  wb_entry_t                       push1_entry,
    input  logic                            pop_en,
    output wb_entry_t                       head,
    output logic [CNT_W-1:0]                count,
    output logic [DEPTH-1:0]                entry_valid,
    output logic [DEPTH-1:0][WB_ADDR_W-1:0] entry_rd
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    wb_entry_t        r_mem [DEPTH];

    logic [PTR_W-1:0] w_wr_ptr_p1;
    logic [1:0]       w_push_cnt;

    assign w_wr_ptr_p1 = r_wr_ptr + PTR_W'(1);
    assign w_push_cnt  = {1'b0, push0_en} + {1'b0, push1_en};

    // Pushes are compacted: a lone push1 lands at the write pointer so the
    // storage never contains holes.
    always_ff @(posedge clk) begin
        if (push0_en) begin
            r_mem[r_wr_ptr] <= push0_entry;
            if (push1_en) begin
                r_mem[w_wr_ptr_p1] <= push1_entry;
            end
        end else if (push1_en) begin
            r_mem[r_wr_ptr] <= push1_entry;
        end
    end

    // Pointers are power-of-two sized, so natural overflow is the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_cnt);
            r_rd_ptr <= r_rd_ptr + PTR_W'(pop_en);
            r_count  <= r_count + CNT_W'(w_push_cnt) - CNT_W'(pop_en);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

    // A slot is live when its distance from the read pointer is below the
    // occupancy; this stays correct across pointer wrap.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PTR_W-1:0] w_off;
        assign w_off          = PTR_W'(i) - r_rd_ptr;
        assign entry_valid[i] = (CNT_W'(w_off) < r_count);
        assign entry_rd[i]    = r_mem[i].rd;
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Writeback arbiter. Accepts ALU and load results over
//             valid/ready, drops x0 destinations, queues the rest in order
//             (load ahead of ALU in the same cycle) and drives the single
//             register-file write port from a registered output stage.
//             Also publishes a mask of destinations still pending.
//  Ports    : clk, rst_n                      - clock, async active-low reset
//             ld_valid/ld_ready/ld_rd/ld_data - load result handshake
//             alu_valid/alu_ready/alu_rd/alu_data - ALU result handshake
//             reg_write_en/dest/data          - registered write port
//             busy_mask                       - pending destination bits
//             q_count                         - queue occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import riscv_wb_pkg::*;
#(
    // Entry widths come from wb_entry_t; keep these at the package values.
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [ADDR_W-1:0]          ld_rd,
    input  logic [DATA_W-1:0]          ld_data,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    output logic                       reg_write_en,
    output logic [ADDR_W-1:0]          reg_write_dest,
    output logic [DATA_W-1:0]          reg_write_data,
    output logic [2**ADDR_W-1:0]       busy_mask,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_depth_m1 = CNT_W'(DEPTH - 1);

    logic                           w_ld_fire;
    logic                           w_alu_fire;
    logic                           w_push0;
    logic                           w_push1;
    logic                           w_pop;
    wb_entry_t                      w_ld_entry;
    wb_entry_t                      w_alu_entry;
    wb_entry_t                      w_head;
    logic [CNT_W-1:0]               w_count;
    logic [DEPTH-1:0]               w_entry_valid;
    logic [DEPTH-1:0][ADDR_W-1:0]   w_entry_rd;
    logic [2**ADDR_W-1:0]           w_busy;

    logic                           r_we;
    logic [ADDR_W-1:0]              r_dest;
    logic [DATA_W-1:0]              r_data;

    // Readies look only at current occupancy. A same-cycle pop is ignored,
    // which may stall one cycle early but can never overflow the queue.
    assign ld_ready  = (w_count < c_depth);
    assign alu_ready = (w_count < c_depth_m1) || (!ld_valid && (w_count < c_depth));

    assign w_ld_fire  = ld_valid  && ld_ready;
    assign w_alu_fire = alu_valid && alu_ready;

    // x0 results complete their handshake but are never queued.
    assign w_push0 = w_ld_fire  && (ld_rd  != X0);
    assign w_push1 = w_alu_fire && (alu_rd != X0);

    assign w_ld_entry  = '{rd: ld_rd,  data: ld_data};
    assign w_alu_entry = '{rd: alu_rd, data: alu_data};

    assign w_pop = (w_count != '0);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push0_en    (w_push0),
        .push0_entry (w_ld_entry),
        .push1_en    (w_push1),
        .push1_entry (w_alu_entry),
        .pop_en      (w_pop),
        .head        (w_head),
        .count       (w_count),
        .entry_valid (w_entry_valid),
        .entry_rd    (w_entry_rd)
    );

    // Output stage: one write per cycle whenever the queue has data.
    // Dest/data hold their last values while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_dest <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_pop;
            if (w_pop) begin
                r_dest <= w_head.rd;
                r_data <= w_head.data;
            end
        end
    end

    // Pending destinations: every live queue slot plus the output stage
    // while it is writing.
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                w_busy[w_entry_rd[i]] = 1'b1;
            end
        end
        if (r_we) begin
            w_busy[r_dest] = 1'b1;
        end
        w_busy[0] = 1'b0;
    end

    assign busy_mask      = w_busy;
    assign q_count        = w_count;
    assign reg_write_en   = r_we;
    assign reg_write_dest = r_dest;
    assign reg_write_data = r_data;

endmodule
`default_nettype wire
